bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: BUS_ARBITER

Interface
REQ-001 SHALL have parameter DWidth, default 32, bus address width.
REQ-002 SHALL have parameter NumofMaster, default 2, number of requesting masters (2..8).
REQ-003 SHALL have local parameter IdxWidth = $clog2(NumofMaster), owner index width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port req_i[0:NumofMaster-1], input, 1 bit each: master requests a transfer.
REQ-008 SHALL have port addr_i[0:NumofMaster-1], input, DWidth each: per-master transfer address.
REQ-009 SHALL have port ready_i, input, 1 bit: bus data-phase completion (bus ready_o).
REQ-010 SHALL have port resp_i, input, 1 bit: bus error response, valid when ready_i=1.
REQ-011 SHALL have port addr_o, output, DWidth: muxed address to bus.
REQ-012 SHALL have port trans_o, output, 1 bit: address-phase valid to bus.
REQ-013 SHALL have port grant_o[0:NumofMaster-1], output, 1 bit each: one-hot ownership.
REQ-014 SHALL have port owner_o, output, IdxWidth: current owner index.
REQ-015 SHALL have port done_o[0:NumofMaster-1], output, 1 bit each: one-cycle completion pulse.
REQ-016 SHALL have port err_o[0:NumofMaster-1], output, 1 bit each: done_o qualified by resp_i.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-018 IDLE: if any req_i=1, SHALL register the round-robin winner as owner and go to ADDR; else stay in IDLE.
REQ-019 Round-robin search SHALL start at index last_owner+1 modulo NumofMaster and pick the first requester.
REQ-020 ADDR SHALL last exactly one cycle, with trans_o=1 and addr_o=addr_i[owner], then go to DATA.
REQ-021 DATA SHALL hold trans_o=0 and wait for ready_i=1 for an unbounded number of cycles.
REQ-022 On ready_i=1 in DATA: done_o[owner]=1 and err_o[owner]=resp_i (combinational, same cycle); last_owner is set to owner.
REQ-023 On ready_i=1 in DATA with any req_i=1: SHALL re-arbitrate from owner+1 and go directly to ADDR (no IDLE bubble); with none, go to IDLE.
REQ-024 grant_o SHALL be one-hot at owner in ADDR and DATA, and all-zero in IDLE.
REQ-025 Grant latency: a request in IDLE at cycle N SHALL produce grant_o and trans_o at cycle N+1.
REQ-026 req_i deassertion during ADDR or DATA SHALL be ignored; the transfer always completes.
REQ-027 A single persistent requester SHALL be re-granted back-to-back, one ADDR per completion.
REQ-028 addr_o SHALL be 0 and owner_o SHALL hold last_owner outside ADDR.

Reset
REQ-029 rst_i=1 SHALL force IDLE with last_owner=NumofMaster-1, so master 0 wins first.
REQ-030 During rst_i=1, all grant_o, done_o, err_o, trans_o and addr_o SHALL be 0.
REQ-031 Reset during DATA SHALL abandon the transfer with no done_o pulse.

Configuration
REQ-032 Macro BUS_ARB_LOCK_EN, when defined, SHALL add input lock_i[0:NumofMaster-1].
REQ-033 With BUS_ARB_LOCK_EN: on completion, if lock_i[owner]=1 and req_i[owner]=1, the same owner SHALL be re-granted regardless of other requests, and last_owner SHALL not advance.
REQ-034 Without BUS_ARB_LOCK_EN: the lock_i port SHALL be absent and behaviour is pure round-robin.

Structure
REQ-035 Package bus_arb_pkg SHALL hold the arb_state_e enum (IDLE, ADDR, DATA) and the reset-pointer constant.
REQ-036 Sub-module RR_PICKER SHALL be combinational: inputs request vector and start index; outputs valid and winner index.

Verification
REQ-037 Reset, then req_i={1,1} held, ready_i=1 every DATA cycle -> owners 0,1,0,1; one trans_o per ADDR; no IDLE cycles.
REQ-038 Only master1 requests, ready_i delayed 3 cycles -> grant_o[1] held 4 DATA cycles; done_o[1] pulses once.
REQ-039 Completion with resp_i=1 -> err_o[owner]=1 and done_o[owner]=1 in the same cycle; other err_o=0.
REQ-040 rst_i asserted mid-DATA -> next cycle IDLE, all grants 0, no done_o; next request from both masters grants master 0.
REQ-041 With BUS_ARB_LOCK_EN, master0 lock_i=1 and both requesting -> master0 wins 3 consecutive transfers; after lock_i drops, master1 wins.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types for the bus arbiter: FSM state encoding and reset pointer.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // After reset the last-owner pointer sits this far below the master count,
    // i.e. on the highest index, so master 0 is the first round-robin winner.
    localparam int RstPtrOffset = 1;

    function automatic int reset_ptr(input int num_master);
        return num_master - RstPtrOffset;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
module bus_arbiter_rr_picker
    import bus_arb_pkg::*;
#(
    parameter  int NumofMaster = 2,
    localparam int IdxWidth    = $clog2(NumofMaster)
) (
    input  logic [NumofMaster-1:0] req_i,
    input  logic [IdxWidth-1:0]    start_i,
    output logic                   valid_o,
    output logic [IdxWidth-1:0]    winner_o
);

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        // Walk from the farthest offset down so the nearest requester is assigned last.
        for (int i = NumofMaster - 1; i >= 0; i--) begin
            if (req_i[(int'(start_i) + i) % NumofMaster]) begin
                valid_o  = 1'b1;
                winner_o = IdxWidth'((int'(start_i) + i) % NumofMaster);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with IDLE/ADDR/DATA sequencing.
// Optional owner locking is compiled in with `define BUS_ARB_LOCK_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int DWidth      = 32,
    parameter  int NumofMaster = 2,
    localparam int IdxWidth    = $clog2(NumofMaster)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i   [NumofMaster],
    input  logic [DWidth-1:0] addr_i  [NumofMaster],
`ifdef BUS_ARB_LOCK_EN
    input  logic              lock_i  [NumofMaster],
`endif
    input  logic              ready_i,
    input  logic              resp_i,
    output logic [DWidth-1:0] addr_o,
    output logic              trans_o,
    output logic              grant_o [NumofMaster],
    output logic [IdxWidth-1:0] owner_o,
    output logic              done_o  [NumofMaster],
    output logic              err_o   [NumofMaster],
    output arb_state_e        state_o
);

    arb_state_e            state_q, state_d;
    logic [IdxWidth-1:0]   owner_q, owner_d;
    logic [NumofMaster-1:0] req_vec;
    logic [IdxWidth-1:0]   rr_start;
    logic                  pick_valid;
    logic [IdxWidth-1:0]   pick_winner;
    logic                  lock_hold;
    logic                  active;
    logic                  in_addr;
    logic                  complete;

    always_comb begin
        req_vec = '0;
        for (int m = 0; m < NumofMaster; m++) begin
            req_vec[m] = req_i[m];
        end
    end

    // owner_q doubles as last_owner: it keeps the previous owner once the bus goes idle.
    assign rr_start = (owner_q == IdxWidth'(NumofMaster - 1)) ? '0 : owner_q + IdxWidth'(1);

    bus_arbiter_rr_picker #(
        .NumofMaster(NumofMaster)
    ) u_picker (
        .req_i   (req_vec),
        .start_i (rr_start),
        .valid_o (pick_valid),
        .winner_o(pick_winner)
    );

`ifdef BUS_ARB_LOCK_EN
    assign lock_hold = lock_i[owner_q] & req_i[owner_q];
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                if (ready_i) begin
                    if (lock_hold) begin
                        state_d = ADDR;
                    end else if (pick_valid) begin
                        owner_d = pick_winner;
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= IdxWidth'(reset_ptr(NumofMaster));
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Every bus-facing output is forced low while reset is held, even mid-transfer.
    assign active   = ~rst_i;
    assign in_addr  = active && (state_q == ADDR);
    assign complete = active && (state_q == DATA) && ready_i;

    always_comb begin
        trans_o = in_addr;
        addr_o  = in_addr ? addr_i[owner_q] : '0;
        owner_o = owner_q;
        state_o = state_q;
        for (int m = 0; m < NumofMaster; m++) begin
            grant_o[m] = active && (state_q != IDLE) && (owner_q == IdxWidth'(m));
            done_o[m]  = complete && (owner_q == IdxWidth'(m));
            err_o[m]   = complete && (owner_q == IdxWidth'(m)) && resp_i;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction-level model predicts grants,
// address phases and completions; a separate monitor compares DUT output against them.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int DW = 32;
    localparam int NM = 2;
`ifdef BUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_i   [NM];
    logic [DW-1:0] addr_i  [NM];
`ifdef BUS_ARB_LOCK_EN
    logic          lock_i  [NM];
`endif
    logic          ready_i;
    logic          resp_i;
    logic [DW-1:0] addr_o;
    logic          trans_o;
    logic          grant_o [NM];
    logic [0:0]    owner_o;
    logic          done_o  [NM];
    logic          err_o   [NM];
    arb_state_e    state_o;

    bus_arbiter #(.DWidth(DW), .NumofMaster(NM)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .addr_i (addr_i),
`ifdef BUS_ARB_LOCK_EN
        .lock_i (lock_i),
`endif
        .ready_i(ready_i),
        .resp_i (resp_i),
        .addr_o (addr_o),
        .trans_o(trans_o),
        .grant_o(grant_o),
        .owner_o(owner_o),
        .done_o (done_o),
        .err_o  (err_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Packed views of the per-master signals.
    logic [NM-1:0] req_v, lck_v, gnt_v, done_v, err_v;
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            req_v[m]  = req_i[m];
            gnt_v[m]  = grant_o[m];
            done_v[m] = done_o[m];
            err_v[m]  = err_o[m];
        end
    end

    typedef struct {int cyc; int own; logic [DW-1:0] addr;} addr_ev_t;
    typedef struct {int cyc; int own; bit err;} done_ev_t;

    logic [NM-1:0] exp_q[$];
    addr_ev_t      addr_q[$];
    done_ev_t      done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with no prediction (cycle %0d)", name, cyc);
    endtask

    function automatic int rr_pick(input int last, input logic [NM-1:0] req);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    // Reference model: a bus that is either free or carrying one transfer for cur.
    initial begin
        bit busy  = 1'b0;
        bit fresh = 1'b0;
        int cur   = 0;
        int last  = NM - 1;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                exp_q.push_back('0);
                busy = 1'b0;
                fresh = 1'b0;
                last = NM - 1;
            end else if (!busy) begin
                exp_q.push_back('0);
                if (req_v != '0) begin
                    cur = rr_pick(last, req_v);
                    busy = 1'b1;
                    fresh = 1'b1;
                end
            end else begin
                exp_q.push_back(NM'(1) << cur);
                if (fresh) begin
                    addr_q.push_back('{cyc, cur, addr_i[cur]});
                    fresh = 1'b0;
                end else if (ready_i) begin
                    done_q.push_back('{cyc, cur, resp_i});
                    last = cur;
                    if (LOCK_EN && lck_v[cur] && req_v[cur]) begin
                        fresh = 1'b1;
                    end else if (req_v != '0) begin
                        cur = rr_pick(last, req_v);
                        fresh = 1'b1;
                    end else begin
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: samples just after the falling edge, after the model has predicted.
    initial begin
        addr_ev_t ae;
        done_ev_t de;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) unexpected("grant");
            else check("grant", gnt_v, exp_q.pop_front());
            if (rst_i) begin
                check("reset_outputs", {trans_o, done_v, err_v, addr_o}, '0);
            end
            if (trans_o) begin
                if (addr_q.size() == 0) begin
                    unexpected("trans");
                end else begin
                    ae = addr_q.pop_front();
                    check("trans_cycle", cyc, ae.cyc);
                    check("trans_owner", owner_o, ae.own);
                    check("trans_addr", addr_o, ae.addr);
                end
            end else begin
                check("addr_idle_zero", addr_o, '0);
            end
            if (done_v != '0) begin
                if (done_q.size() == 0) begin
                    unexpected("done");
                end else begin
                    de = done_q.pop_front();
                    check("done_cycle", cyc, de.cyc);
                    check("done_vec", done_v, NM'(1) << de.own);
                    check("err_vec", err_v, de.err ? (NM'(1) << de.own) : '0);
                end
            end else begin
                check("err_without_done", err_v, '0);
            end
        end
    end

    task automatic drive(input bit rst, input logic [NM-1:0] req, input bit rdy,
                         input bit rsp, input logic [NM-1:0] lck, input int n);
        rst_i   = rst;
        ready_i = rdy;
        resp_i  = rsp;
        lck_v   = lck;
        for (int m = 0; m < NM; m++) begin
            req_i[m]  = req[m];
            addr_i[m] = $urandom;
`ifdef BUS_ARB_LOCK_EN
            lock_i[m] = lck[m];
`endif
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        drive(1'b0, '0, 1'b1, 1'b0, '0, 3);
    endtask

    initial begin
        drive(1'b1, '0, 1'b0, 1'b0, '0, 3);
        check("reset_owner", owner_o, NM - 1);
        check("reset_state", state_o, IDLE);

        // Both masters requesting, bus always ready: 0,1,0,1 with no idle gaps.
        drive(1'b0, 2'b11, 1'b1, 1'b0, '0, 9);
        go_idle();

        // Master 1 alone, three wait states, request dropped during the transfer.
        drive(1'b0, 2'b10, 1'b0, 1'b0, '0, 2);
        drive(1'b0, 2'b00, 1'b0, 1'b0, '0, 3);
        drive(1'b0, 2'b00, 1'b1, 1'b0, '0, 1);
        go_idle();

        // Error response on completion.
        drive(1'b0, 2'b01, 1'b0, 1'b0, '0, 2);
        drive(1'b0, 2'b00, 1'b1, 1'b1, '0, 1);
        go_idle();

        // Reset while in the data phase with ready high: no completion pulse.
        drive(1'b0, 2'b11, 1'b0, 1'b0, '0, 2);
        drive(1'b1, 2'b11, 1'b1, 1'b0, '0, 1);
        drive(1'b0, 2'b11, 1'b0, 1'b0, '0, 3);
        drive(1'b0, 2'b11, 1'b1, 1'b0, '0, 1);
        go_idle();

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) == 0, NM'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                  NM'($urandom_range(0, 3)), 1);
        end
        go_idle();

        if (LOCK_EN) begin
            // Master 0 locked for three transfers, then master 1 gets the bus.
            drive(1'b1, '0, 1'b0, 1'b0, '0, 2);
            drive(1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 6);
            drive(1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 4);
            go_idle();
        end

        @(negedge clk);
        #2;
        check("addr_q_drained", addr_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
